// File: rtl/led_strip_pkg.sv
// Shared types and framing constants for the LED strip transmitter.
package led_strip_pkg;

   typedef enum logic [2:0] {IDLE, START, LOAD, SHIFT, END} state_t;

   localparam int START_BITS = 32;
   localparam int PIX_BITS = 32;
   localparam logic [31:0] HEADER_MASK = 32'hE000_0000;

endpackage

// File: rtl/led_strip_tx_bit_timer.sv
// Half-period divider for the strip clock: low phase then high phase, CLK_DIV cycles each.
module led_bit_timer #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic phase,
   output logic bit_end
);

   localparam int HW = $clog2(CLK_DIV + 1);
   localparam logic [HW-1:0] RELOAD = HW'(CLK_DIV - 1);

   logic [HW-1:0] hcnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcnt  <= RELOAD;
         phase <= 1'b0;
      end else if (!en) begin
         hcnt  <= RELOAD;
         phase <= 1'b0;
      end else if (hcnt == '0) begin
         hcnt  <= RELOAD;
         phase <= ~phase;
      end else begin
         hcnt <= hcnt - HW'(1);
      end
   end

   assign bit_end = en & phase & (hcnt == '0);

endmodule

// File: rtl/led_strip_tx.sv
// Frames pixel words into a strip stream: 32 zero bits, one word per LED (MSB first), END_BITS zeros.
//
// state | meaning
// IDLE  | waiting for start
// START | sending 32 zero start bits
// LOAD  | pix_ready high, waiting for the next pixel word
// SHIFT | sending the captured word, MSB first
// END   | sending END_BITS zero bits, frame_done on exit
module led_strip_tx
   import led_strip_pkg::*;
#(
   parameter int NUM_LEDS     = 64,
   parameter int END_BITS     = 64,
   parameter int CLK_DIV      = 1,
   parameter bit FORCE_HEADER = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   input  logic [31:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        led_clk,
   output logic        led_data,
   output logic        frame_done
);

   localparam int PW = $clog2(NUM_LEDS + 1);
   localparam logic [PW-1:0] PIX_TOTAL = PW'(NUM_LEDS);
   localparam logic [7:0] START_LAST = 8'(START_BITS - 1);
   localparam logic [7:0] PIX_LAST   = 8'(PIX_BITS - 1);
   localparam logic [7:0] END_LAST   = 8'(END_BITS - 1);

   state_t state, state_nx;
   logic [7:0] bit_cnt;
   logic [PW-1:0] pix_cnt, pix_inc;
   logic [31:0] shift_reg;
   logic tmr_en, phase, bit_end, done_nx;

   assign tmr_en  = (state == START) || (state == SHIFT) || (state == END);
   assign pix_inc = pix_cnt + PW'(1);

   led_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .en      (tmr_en),
      .phase   (phase),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         frame_done <= done_nx;
         busy       <= (state_nx != IDLE) || done_nx;
      end
   end

   // start is blocked during the frame_done cycle so a coincident request cannot chain frames
   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      unique case (state)
         IDLE:  if (start && !frame_done) state_nx = START;
         START: if (bit_end && bit_cnt == START_LAST) state_nx = LOAD;
         LOAD:  if (pix_valid) state_nx = SHIFT;
         SHIFT: if (bit_end && bit_cnt == PIX_LAST) state_nx = (pix_inc == PIX_TOTAL) ? END : LOAD;
         END: begin
            if (bit_end && bit_cnt == END_LAST) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt   <= 8'd0;
         pix_cnt   <= '0;
         shift_reg <= 32'd0;
      end else begin
         if (state_nx != state)
            bit_cnt <= 8'd0;
         else if (bit_end)
            bit_cnt <= bit_cnt + 8'd1;

         if (state == IDLE)
            pix_cnt <= '0;
         else if (state == SHIFT && bit_end && bit_cnt == PIX_LAST)
            pix_cnt <= pix_inc;

         if (state == LOAD && pix_valid)
            shift_reg <= FORCE_HEADER ? (pix_data | HEADER_MASK) : pix_data;
         else if (state == SHIFT && bit_end)
            shift_reg <= {shift_reg[30:0], 1'b0};
      end
   end

   assign pix_ready = (state == LOAD);
   assign led_clk   = tmr_en & phase;
   assign led_data  = (state == SHIFT) & shift_reg[31];

endmodule

// File: tb/tb_led_strip_tx.sv
// Bench for led_strip_tx: two configurations checked cycle by cycle against a bit-stream model.
module tb_led_strip_tx;

   logic clk = 1'b0;
   logic reset;
   logic [1:0] start_s, pix_valid_s;
   logic [31:0] pix_data_s [2];
   logic [1:0] busy_o, pix_ready_o, led_clk_o, led_data_o, frame_done_o;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   led_strip_tx dut_a (
      .clk(clk), .reset(reset), .start(start_s[0]), .busy(busy_o[0]),
      .pix_data(pix_data_s[0]), .pix_valid(pix_valid_s[0]), .pix_ready(pix_ready_o[0]),
      .led_clk(led_clk_o[0]), .led_data(led_data_o[0]), .frame_done(frame_done_o[0])
   );

   led_strip_tx #(.NUM_LEDS(2), .END_BITS(64), .CLK_DIV(3), .FORCE_HEADER(1'b0)) dut_b (
      .clk(clk), .reset(reset), .start(start_s[1]), .busy(busy_o[1]),
      .pix_data(pix_data_s[1]), .pix_valid(pix_valid_s[1]), .pix_ready(pix_ready_o[1]),
      .led_clk(led_clk_o[1]), .led_data(led_data_o[1]), .frame_done(frame_done_o[1])
   );

   function automatic int cfg_div(input int i);  return (i == 0) ? 1 : 3;  endfunction
   function automatic int cfg_leds(input int i); return (i == 0) ? 64 : 2; endfunction
   function automatic int cfg_end(input int i);  return 64;                endfunction
   function automatic bit cfg_hdr(input int i);  return (i == 0);          endfunction

   // Model: mode 0 idle, 1 emitting bits of m_word, 2 waiting for a pixel.
   // Segment 0 start zeros, 1 pixel word, 2 end zeros.
   int m_mode [2];
   int m_seg [2];
   int m_left [2];
   int m_t [2];
   int m_pix [2];
   logic [31:0] m_word [2];
   logic m_done [2];

   function automatic void model_step(input int i);
      logic was_done;
      was_done = m_done[i];
      m_done[i] = 1'b0;
      case (m_mode[i])
         0: if (start_s[i] && !was_done) begin
            m_mode[i] = 1; m_seg[i] = 0; m_word[i] = 32'd0;
            m_left[i] = 32; m_t[i] = 0; m_pix[i] = cfg_leds(i);
         end
         1: begin
            m_t[i] = m_t[i] + 1;
            if (m_t[i] == 2 * cfg_div(i)) begin
               m_t[i] = 0;
               m_word[i] = m_word[i] << 1;
               m_left[i] = m_left[i] - 1;
               if (m_left[i] == 0) begin
                  if (m_seg[i] == 2) begin
                     m_mode[i] = 0; m_done[i] = 1'b1;
                  end else if (m_seg[i] == 1 && m_pix[i] == 0) begin
                     m_seg[i] = 2; m_word[i] = 32'd0; m_left[i] = cfg_end(i);
                  end else begin
                     m_mode[i] = 2;
                  end
               end
            end
         end
         default: if (pix_valid_s[i]) begin
            m_word[i] = pix_data_s[i] | (cfg_hdr(i) ? 32'hE000_0000 : 32'h0);
            m_left[i] = 32; m_t[i] = 0; m_seg[i] = 1; m_mode[i] = 1;
            m_pix[i] = m_pix[i] - 1;
         end
      endcase
   endfunction

   function automatic logic [4:0] model_out(input int i);
      return {(m_mode[i] != 0) || m_done[i], m_done[i], m_mode[i] == 2,
              (m_mode[i] == 1) && (m_t[i] >= cfg_div(i)), (m_mode[i] == 1) && m_word[i][31]};
   endfunction

   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_mode[i] = 0; m_seg[i] = 0; m_left[i] = 0; m_t[i] = 0;
            m_pix[i] = 0; m_word[i] = 32'd0; m_done[i] = 1'b0;
         end else begin
            model_step(i);
         end
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Per-cycle compare plus a strip receiver sampling led_data on each rising led_clk.
   logic [1:0] prev_clk = 2'b00;
   logic [1:0] prev_busy = 2'b00;
   int rx_cnt [2];
   int hs_cnt [2];
   int stall_cnt [2];
   int rx_total [2];
   logic [31:0] rx_sh [2];
   logic [31:0] rx_head [2];
   logic [31:0] rx_first [2];
   logic [31:0] rx_last [2];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [4:0] act;
         act = {busy_o[i], frame_done_o[i], pix_ready_o[i], led_clk_o[i], led_data_o[i]};
         if (!reset) begin
            total++;
            if (act !== model_out(i)) begin
               bad++;
               $display("FAIL cycle_compare dut%0d t=%0t outputs(busy,done,ready,clk,data)=%b required=%b",
                        i, $time, act, model_out(i));
            end
         end
         if (busy_o[i] && !prev_busy[i]) begin
            rx_cnt[i] = 0; hs_cnt[i] = 0; stall_cnt[i] = 0;
         end
         if (led_clk_o[i] && !prev_clk[i]) begin
            rx_sh[i] = {rx_sh[i][30:0], led_data_o[i]};
            rx_cnt[i] = rx_cnt[i] + 1;
            if (rx_cnt[i] == 32) rx_head[i] = rx_sh[i];
            if (rx_cnt[i] == 64) rx_first[i] = rx_sh[i];
         end
         if (pix_ready_o[i]) begin
            if (pix_valid_s[i]) hs_cnt[i] = hs_cnt[i] + 1;
            else stall_cnt[i] = stall_cnt[i] + 1;
         end
         if (frame_done_o[i]) begin
            rx_total[i] = rx_cnt[i];
            rx_last[i] = rx_sh[i];
         end
         prev_clk[i] = led_clk_o[i];
         prev_busy[i] = busy_o[i];
      end
   end

   // mode 0: valid tied high; 1: ten-cycle stall before the fifth pixel; 2: random valid.
   // word 0 means random data every cycle.
   task automatic run_frame(input int i, input int mode, input logic [31:0] word,
                            input bit mid_start, input int abort_hs, output int cyc);
      int stall_left;
      int abort_wait;
      bit fin;
      stall_left = 10; abort_wait = 7; fin = 1'b0; cyc = 0;
      pix_data_s[i] = (word == 32'd0) ? $urandom : word;
      pix_valid_s[i] = 1'b1;
      @(posedge clk); #1;
      start_s[i] = 1'b1;
      @(posedge clk); #1;
      start_s[i] = 1'b0;
      while (!fin && cyc < 30000) begin
         @(posedge clk);
         cyc++;
         #1;
         if (frame_done_o[i]) fin = 1'b1;
         if (word == 32'd0) pix_data_s[i] = $urandom;
         case (mode)
            1: begin
               if (hs_cnt[i] == 4 && stall_left > 0) begin
                  pix_valid_s[i] = 1'b0;
                  if (pix_ready_o[i]) stall_left--;
               end else begin
                  pix_valid_s[i] = 1'b1;
               end
            end
            2: pix_valid_s[i] = ($urandom_range(0, 3) != 0);
            default: pix_valid_s[i] = 1'b1;
         endcase
         start_s[i] = mid_start && (cyc == 100 || frame_done_o[i]);
         if (abort_hs != 0 && hs_cnt[i] == abort_hs) begin
            abort_wait--;
            if (abort_wait == 0) begin
               #2;
               reset = 1'b1;
               #1;
               check("reset_outputs_async", {busy_o[i], frame_done_o[i], pix_ready_o[i],
                     led_clk_o[i], led_data_o[i]}, 0);
               fin = 1'b1;
            end
         end
      end
      if (!fin) begin
         total++;
         bad++;
         $display("FAIL frame_timeout dut%0d cycles=%0d required_done_within=30000", i, cyc);
      end
      @(negedge clk); #1;
      start_s[i] = 1'b0;
   endtask

   initial begin
      int cyc;
      reset = 1'b1;
      start_s = 2'b00;
      pix_valid_s = 2'b00;
      pix_data_s[0] = 32'd0;
      pix_data_s[1] = 32'd0;
      @(negedge clk);
      check("reset_state", {busy_o, frame_done_o, pix_ready_o, led_clk_o, led_data_o}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      run_frame(0, 0, 32'h0F00_00FF, 1'b0, 0, cyc);
      check("default_len", cyc, 4352);
      check("default_head", rx_head[0], 32'h0);
      check("default_first_word", rx_first[0], 32'hEF00_00FF);
      check("default_tail", rx_last[0], 32'h0);
      check("default_bit_count", rx_total[0], 2144);

      run_frame(0, 1, 32'd0, 1'b0, 0, cyc);
      check("stall_len", cyc, 4362);
      check("stall_cycles", stall_cnt[0], 10);

      run_frame(0, 2, 32'd0, 1'b0, 0, cyc);
      check("random_valid_len", cyc, 4352 + stall_cnt[0]);

      run_frame(0, 0, 32'hA5A5_5A5A, 1'b1, 0, cyc);
      check("ignored_start_len", cyc, 4352);
      @(posedge clk); #1;
      check("busy_after_done", busy_o[0], 0);
      repeat (30) @(posedge clk);
      #1;
      check("no_second_frame", busy_o[0], 0);

      run_frame(0, 0, 32'd0, 1'b0, 20, cyc);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("idle_after_reset", busy_o[0], 0);
      run_frame(0, 0, 32'h0F00_00FF, 1'b0, 0, cyc);
      check("post_reset_len", cyc, 4352);
      check("post_reset_first_word", rx_first[0], 32'hEF00_00FF);
      check("post_reset_bit_count", rx_total[0], 2144);

      run_frame(1, 0, 32'h1234_5678, 1'b0, 0, cyc);
      check("div3_len", cyc, 962);
      check("div3_first_word", rx_first[1], 32'h1234_5678);
      check("div3_head", rx_head[1], 32'h0);
      check("div3_tail", rx_last[1], 32'h0);
      check("div3_bit_count", rx_total[1], 160);

      run_frame(1, 2, 32'd0, 1'b0, 0, cyc);
      check("div3_random_len", cyc, 962 + stall_cnt[1]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
